// File: rtl/game_input_ctrl.sv
// game_input_ctrl: input stage for the 4x4 light-toggle board.
// Debounces the raw buttons and switches, checks that the switch selection is
// one-hot, and drives registered row/column enables and a one-cycle fire strobe
// to the cell array.
// Define GAME_MIX_EN to add a sequencer that scrambles the board with LFSR-chosen moves.
// Ports:
//   clk       system clock
//   reset     asynchronous reset, active-low
//   fire_btn  raw fire button
//   mix_btn   raw mix button (used only with GAME_MIX_EN)
//   sw[3:0]   raw row/column select switches, one-hot expected
//   n_row     raw switch: 0 = sw picks a row, 1 = sw picks a column
//   row_en    one-hot row enable to the cell array
//   col_en    one-hot column enable to the cell array
//   fire      one-cycle fire strobe to the cell array
//   error     debounced sw is not one-hot
//   mixing    mix sequencer owns the outputs
module game_input_ctrl #(
    parameter int          DB_CYCLES = 1_000_000,
    parameter int          MIX_MOVES = 16,
    parameter int          MIX_GAP   = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire_btn,
    input  logic       mix_btn,
    input  logic [3:0] sw,
    input  logic       n_row,
    output logic [3:0] row_en,
    output logic [3:0] col_en,
    output logic       fire,
    output logic       error,
    output logic       mixing
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    // Bit layout: [3:0] sw, [4] fire_btn, [5] mix_btn, [6] n_row
    logic [6:0]    raw, s1_q, s2_q, db_q, db_d;
    logic [CW-1:0] cnt_q [7];
    logic [CW-1:0] cnt_d [7];
    logic [3:0]    row_en_q, row_en_d, col_en_q, col_en_d;
    logic          fire_q, fire_d, error_q, error_d, mixing_q, fire_prev_q;
    logic          sel_err, fire_norm;
    logic          mix_busy, mix_fire;
    logic [3:0]    mix_row, mix_col;

    assign raw = {n_row, mix_btn, fire_btn, sw};

    // For a 1-bit input, "synced differs from debounced" already implies the
    // synced value has not flipped back, so one equality test clears the count.
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) db_d[i] = s2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign sel_err = !$onehot(db_q[3:0]);

`ifdef GAME_MIX_EN
    localparam int GW = $clog2(MIX_GAP + 1);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, PICK = 3'd2, ARM = 3'd3, FIRE = 3'd4, GAP = 3'd5;

    logic [2:0]    state_q, state_d, pick_q, pick_d;
    logic [7:0]    moves_q, moves_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          mix_prev_q;

    always_comb begin
        state_d = state_q;
        pick_d  = pick_q;
        moves_d = moves_q;
        gap_d   = gap_q;
        lfsr_d  = (lfsr_q == 16'd0) ? LFSR_SEED
                : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        case (state_q)
            IDLE: if (db_q[5] && !mix_prev_q) state_d = LOAD;
            LOAD: begin
                moves_d = 8'(MIX_MOVES);
                state_d = PICK;
            end
            PICK: begin
                pick_d  = lfsr_q[2:0];
                state_d = ARM;
            end
            ARM:  state_d = FIRE;
            FIRE: begin
                gap_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == GW'(MIX_GAP - 1)) begin
                    moves_d = moves_q - 1'b1;
                    state_d = (moves_q == 8'd1) ? IDLE : PICK;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer outputs are decoded from next state so they land in the output flops in step with the FSM.
    assign mix_busy = state_d != IDLE;
    assign mix_fire = state_d == FIRE;
    assign mix_row  = ((state_d == ARM || state_d == FIRE) && !pick_d[0]) ? 4'b0001 << pick_d[2:1] : 4'b0000;
    assign mix_col  = ((state_d == ARM || state_d == FIRE) &&  pick_d[0]) ? 4'b0001 << pick_d[2:1] : 4'b0000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pick_q     <= '0;
            moves_q    <= '0;
            gap_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            mix_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pick_q     <= pick_d;
            moves_q    <= moves_d;
            gap_q      <= gap_d;
            lfsr_q     <= lfsr_d;
            mix_prev_q <= db_q[5];
        end
    end
`else
    logic unused_mix;
    assign unused_mix = db_q[5];
    assign mix_busy   = 1'b0;
    assign mix_fire   = 1'b0;
    assign mix_row    = 4'b0000;
    assign mix_col    = 4'b0000;
`endif

    // Enables are frozen on the edge that launches a fire so they match the cycle before and the fire cycle.
    always_comb begin
        fire_norm = db_q[4] & ~fire_prev_q & ~error_q & ~mixing_q & ~mix_busy;
        fire_d    = mix_fire | fire_norm;
        error_d   = ~mix_busy & sel_err;
        row_en_d  = mix_busy ? mix_row : fire_norm ? row_en_q : (sel_err |  db_q[6]) ? 4'b0000 : db_q[3:0];
        col_en_d  = mix_busy ? mix_col : fire_norm ? col_en_q : (sel_err | ~db_q[6]) ? 4'b0000 : db_q[3:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            db_q        <= '0;
            for (int i = 0; i < 7; i++) cnt_q[i] <= '0;
            fire_prev_q <= 1'b0;
            row_en_q    <= '0;
            col_en_q    <= '0;
            fire_q      <= 1'b0;
            error_q     <= 1'b0;
            mixing_q    <= 1'b0;
        end else begin
            s1_q        <= raw;
            s2_q        <= s1_q;
            db_q        <= db_d;
            for (int i = 0; i < 7; i++) cnt_q[i] <= cnt_d[i];
            fire_prev_q <= db_q[4];
            row_en_q    <= row_en_d;
            col_en_q    <= col_en_d;
            fire_q      <= fire_d;
            error_q     <= error_d;
            mixing_q    <= mix_busy;
        end
    end

    assign row_en = row_en_q;
    assign col_en = col_en_q;
    assign fire   = fire_q;
    assign error  = error_q;
    assign mixing = mixing_q;
endmodule

// File: tb/tb_game_input_ctrl.sv
// tb_game_input_ctrl: scoreboard bench for game_input_ctrl (DB_CYCLES=4, MIX_MOVES=3, MIX_GAP=2).
module tb_game_input_ctrl;
    logic       clk = 1'b0;
    logic       reset, fire_btn, mix_btn, n_row;
    logic [3:0] sw, row_en, col_en;
    logic       fire, error, mixing;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    // bit 8 set: any single enable bit acceptable; else bits [7:0] = {row_en, col_en}
    logic [8:0] exp_q[$];
    logic [7:0] prev_en = 8'h00;
    logic       prev_fire = 1'b0;

    game_input_ctrl #(.DB_CYCLES(4), .MIX_MOVES(3), .MIX_GAP(2), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .fire_btn(fire_btn), .mix_btn(mix_btn), .sw(sw), .n_row(n_row),
        .row_en(row_en), .col_en(col_en), .fire(fire), .error(error), .mixing(mixing)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    // Fire monitor: pops the scoreboard on every strobe.
    always @(negedge clk) begin
        logic [8:0] e;
        if (fire === 1'b1) begin
            pulse_cnt++;
            checks++;
            if (prev_fire) begin
                errors++;
                $display("FAIL fire_width got fire high 2 cycles expected 1");
            end
            checks++;
            if ({row_en, col_en} !== prev_en) begin
                errors++;
                $display("FAIL en_stable got %b expected %b", {row_en, col_en}, prev_en);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_fire got en=%b expected no pulse", {row_en, col_en});
            end else begin
                e = exp_q.pop_front();
                if (e[8] ? !$onehot({row_en, col_en}) : ({row_en, col_en} !== e[7:0])) begin
                    errors++;
                    $display("FAIL fire_en got %b expected %b", {row_en, col_en}, e);
                end
            end
        end
        prev_en = {row_en, col_en};
        prev_fire = fire;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outs(input string name, input logic [3:0] r, input logic [3:0] c, input logic er);
        checks++;
        if ({row_en, col_en, error, fire, mixing} !== {r, c, er, 2'b00}) begin
            errors++;
            $display("FAIL %s got row=%b col=%b err=%b fire=%b mix=%b expected row=%b col=%b err=%b fire=0 mix=0",
                     name, row_en, col_en, error, fire, mixing, r, c, er);
        end
    endtask

    task automatic expect_pulses(input string name, input int want);
        checks++;
        if (pulse_cnt !== want) begin
            errors++;
            $display("FAIL %s got pulses=%0d expected %0d", name, pulse_cnt, want);
        end
    endtask

    task automatic press_fire(input int len, input int settle);
        fire_btn = 1'b1;
        tick(len);
        fire_btn = 1'b0;
        tick(settle);
    endtask

    task automatic test_reset;
        reset = 1'b0; fire_btn = 1'b0; mix_btn = 1'b0; sw = 4'b0000; n_row = 1'b0;
        tick(3);
        check_outs("reset_hold", 4'b0000, 4'b0000, 1'b0);
        reset = 1'b1;
        tick(1);
        check_outs("reset_release_err", 4'b0000, 4'b0000, 1'b1);
    endtask

    task automatic test_select;
        sw = 4'b0100; n_row = 1'b0;
        tick(8);
        check_outs("sel_row", 4'b0100, 4'b0000, 1'b0);
        n_row = 1'b1;
        tick(8);
        check_outs("sel_col", 4'b0000, 4'b0100, 1'b0);
    endtask

    task automatic test_fire;
        int base = pulse_cnt;
        press_fire(2, 12);
        expect_pulses("short_press", base);
        exp_q.push_back({1'b0, 4'b0000, 4'b0100});
        press_fire(20, 12);
        expect_pulses("long_press", base + 1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL long_press_sb got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_error;
        int base = pulse_cnt;
        sw = 4'b0110;
        tick(8);
        check_outs("err_two_bits", 4'b0000, 4'b0000, 1'b1);
        press_fire(20, 12);
        expect_pulses("err_blocks_fire", base);
        sw = 4'b0010; n_row = 1'b0;
        tick(8);
        check_outs("err_clear", 4'b0010, 4'b0000, 1'b0);
        exp_q.push_back({1'b0, 4'b0010, 4'b0000});
        press_fire(20, 12);
        expect_pulses("err_clear_fire", base + 1);
    endtask

    task automatic test_db_boundary;
        int base = pulse_cnt;
        press_fire(3, 12);
        expect_pulses("db_3cyc", base);
        exp_q.push_back({1'b0, 4'b0010, 4'b0000});
        press_fire(4, 12);
        expect_pulses("db_4cyc", base + 1);
        check_outs("db_after", 4'b0010, 4'b0000, 1'b0);
    endtask

`ifdef GAME_MIX_EN
    task automatic test_mix;
        int base = pulse_cnt;
        int last = -1;
        repeat (3) exp_q.push_back(9'h100);
        mix_btn = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (c == 9) begin
                checks++;
                if (mixing !== 1'b1) begin
                    errors++;
                    $display("FAIL mix_active got mixing=%b expected 1", mixing);
                end
            end
            if (fire === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (c - last != 5) begin
                        errors++;
                        $display("FAIL mix_spacing got %0d expected 5", c - last);
                    end
                end
                last = c;
            end
            if (c == 10) fire_btn = 1'b1;
            if (c == 20) mix_btn = 1'b0;
        end
        check_outs("mix_done", 4'b0010, 4'b0000, 1'b0);
        expect_pulses("mix_pulses", base + 3);
        fire_btn = 1'b0;
        tick(12);
        expect_pulses("mix_fire_dropped", base + 3);
    endtask

    task automatic test_mix_reset;
        int base = pulse_cnt;
        int n = 0;
        exp_q.push_back(9'h100);
        mix_btn = 1'b1;
        while (pulse_cnt == base && n < 60) begin
            tick(1);
            n++;
        end
        checks++;
        if (pulse_cnt != base + 1) begin
            errors++;
            $display("FAIL mix_first_move got pulses=%0d expected %0d", pulse_cnt - base, 1);
        end
        mix_btn = 1'b0;
        tick(4);
        #2 reset = 1'b0;
        #1 check_outs("mix_abort", 4'b0000, 4'b0000, 1'b0);
        tick(5);
        reset = 1'b1;
        #1 checks++;
        if (dut.lfsr_q !== 16'hACE1) begin
            errors++;
            $display("FAIL lfsr_seed got %h expected ace1", dut.lfsr_q);
        end
        tick(20);
        expect_pulses("mix_abort_no_pulse", base + 1);
    endtask
`endif

    initial begin
        test_reset;
        test_select;
        test_fire;
        test_error;
        test_db_boundary;
`ifdef GAME_MIX_EN
        test_mix;
        test_mix_reset;
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
